keccak_perm_arbiter: RTL and testbench

- Shares one Keccak-f[1600] `permutation` instance between up to N hash-wrapper requesters, e.g. the SHA3-256 (H), SHA3-512 (G) and SHAKE (XOF/PRF) sponges in the Kyber768 encryption path.
- Arbitrates round-robin, captures the granted requester's 1600-bit state, and sequences the permutation's enable/valid handshake, including the mandatory enable-low gap between runs.
- Returns the permuted state to the granted requester with a one-hot completion pulse.
- Includes a watchdog that flags a permutation that never completes.

---
 rtl/keccak_perm_arbiter.sv | 149 ++++++++++++++
 tb/tb_keccak_perm_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_perm_arbiter.sv
// Round-robin arbiter sharing one Keccak-f[1600] permutation between N sponge requesters.
// Captures the winner's state, drives the enable/valid handshake with a one-cycle gap, and runs a watchdog.
module keccak_perm_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [N*1600-1:0]      req_state,
  output logic [1599:0]          resp_state,
  output logic [N-1:0]           resp_valid,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   timeout_err,
  output logic                   perm_enable,
  output logic [1599:0]          perm_in,
  input  logic [1599:0]          perm_out,
  input  logic                   perm_valid
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   next_ptr;
  logic            any_req;
  logic [1599:0]   winner_state;
  logic [CW-1:0]   wd_cnt;
  logic            grant_fire;
  logic            done_fire;
  logic            expire_fire;

  // Search from the pointer upward with wrap-around; the first set bit wins.
  always_comb begin
    logic [IW:0] pos;
    winner  = '0;
    any_req = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!any_req && req_valid[pos[IW-1:0]]) begin
        winner  = pos[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    winner_state = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IW'(i)) begin
        winner_state = req_state[i*1600 +: 1600];
      end
    end
  end

  // The served requester drops to lowest priority, whether it completed or timed out.
  assign next_ptr = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    perm_enable = 1'b0;
    grant_fire  = 1'b0;
    done_fire   = 1'b0;
    expire_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          grant_fire = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        perm_enable = 1'b1;
        if (perm_valid) begin
          done_fire  = 1'b1;
          state_next = S_GAP;
        end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
          expire_fire = 1'b1;
          state_next  = S_GAP;
        end
      end
      S_GAP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  // Registered datapath; resp_valid defaults low so every completion is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      grant_id    <= '0;
      perm_in     <= '0;
      resp_state  <= '0;
      resp_valid  <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (grant_fire) begin
        grant_id <= winner;
        perm_in  <= winner_state;
        wd_cnt   <= '0;
      end else if (state == S_RUN) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if (done_fire) begin
        resp_state <= perm_out;
        resp_valid <= N'(1) << grant_id;
        ptr        <= next_ptr;
      end
      if (expire_fire) begin
        timeout_err <= 1'b1;
        ptr         <= next_ptr;
      end
    end
  end

  a_resp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid));
  a_enable_run:  assert property (@(posedge clk) disable iff (rst) perm_enable |-> (state == S_RUN));

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Scoreboard bench for keccak_perm_arbiter: a stub permutation with programmable latency,
// a transaction-level arbitration model feeding an expected-response queue, and a decoupled monitor.
module tb_keccak_perm_arbiter;

  localparam int N       = 3;
  localparam int IW      = 2;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        req_valid;
  logic [N*1600-1:0]   req_state;
  logic [1599:0]       resp_state;
  logic [N-1:0]        resp_valid;
  logic                busy;
  logic [IW-1:0]       grant_id;
  logic                timeout_err;
  logic                perm_enable;
  logic [1599:0]       perm_in;
  logic [1599:0]       perm_out;
  logic                perm_valid;

  int   lat        = 10;
  bit   stall_perm = 1'b0;
  bit   spurious   = 1'b0;
  logic [7:0] stub_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int            id;
    logic [1599:0] in_state;
    logic [1599:0] out_state;
    bit            is_timeout;
    int            run_len;
  } exp_t;

  exp_t sb[$];
  int   model_ptr = 0;

  keccak_perm_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_state   (req_state),
    .resp_state  (resp_state),
    .resp_valid  (resp_valid),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .perm_enable (perm_enable),
    .perm_in     (perm_in),
    .perm_out    (perm_out),
    .perm_valid  (perm_valid)
  );

  always #5 clk = ~clk;

  // Stand-in for the permutation: a fixed bijection, valid after lat+1 enabled cycles.
  function automatic logic [1599:0] perm_model(input logic [1599:0] x);
    logic [1599:0] k;
    for (int i = 0; i < 25; i++) k[i*64 +: 64] = 64'hA5A5_5A5A_0F0F_F0F0 ^ 64'(i);
    return {x[1598:0], x[1599]} ^ k;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) stub_cnt <= '0;
    else if (!perm_enable) stub_cnt <= '0;
    else stub_cnt <= stub_cnt + 8'd1;
  end

  assign perm_out   = perm_model(perm_in);
  assign perm_valid = spurious || (perm_enable && !stall_perm && (int'(stub_cnt) == lat));

  task automatic checkOutput(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference: serve requests one at a time in round-robin order from the last served index.
  task automatic modelServe(input logic [N-1:0] mask, input int rearm_limit, input bit stall);
    logic [N-1:0] m = mask;
    int served = 0;
    int w;
    exp_t e;
    while (m != '0) begin
      w = pick(m, model_ptr);
      e.id         = w;
      e.in_state   = req_state[w*1600 +: 1600];
      e.out_state  = perm_model(e.in_state);
      e.is_timeout = stall;
      e.run_len    = stall ? TIMEOUT : lat + 1;
      sb.push_back(e);
      served++;
      m[w] = 1'b0;
      if (served <= rearm_limit) m[w] = 1'b1;
      model_ptr = (w + 1) % N;
    end
  endtask

  task automatic randomizeStates(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      if (mask[i])
        for (int w = 0; w < 50; w++) req_state[i*1600 + w*32 +: 32] = $urandom();
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask, input int latency, input bit stall,
                               input int rearm_limit, input int withdraw_after);
    logic [N-1:0] pend = '0;
    int served = 0;
    int en_cycles = 0;
    bit prev_to;
    bit done = 1'b0;
    lat        = latency;
    stall_perm = stall;
    modelServe(mask, rearm_limit, stall);
    @(negedge clk);
    prev_to   = timeout_err;
    req_valid = mask;
    @(negedge clk);
    checkOutput("grant_latency", perm_enable && busy, {62'b0, busy, perm_enable}, 64'd3);
    if (perm_enable) en_cycles = 1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (perm_enable) en_cycles++;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          req_valid[i] = 1'b1;
          pend[i]      = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (resp_valid[i]) begin
          req_valid[i] = 1'b0;
          served++;
          if (served <= rearm_limit) pend[i] = 1'b1;
        end
      end
      if (timeout_err && !prev_to) req_valid = '0;
      prev_to = timeout_err;
      if (withdraw_after > 0 && en_cycles == withdraw_after) req_valid = '0;
      if (req_valid == '0 && pend == '0 && !busy) done = 1'b1;
    end
    checkOutput("stimulus_done", done, 64'(done), 64'd1);
  endtask

  // Monitor: checks captured state at each grant and pops the scoreboard on every completion or expiry.
  int run_cnt = 0;
  bit prev_en = 1'b0;
  bit prev_to = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      run_cnt = 0;
      prev_en = 1'b0;
      prev_to = 1'b0;
    end else begin
      if (perm_enable) begin
        if (!prev_en) begin
          if (sb.size() == 0) checkOutput("grant_expected", 1'b0, perm_in[63:0], 64'd0);
          else checkOutput("perm_in", perm_in == sb[0].in_state, perm_in[63:0], sb[0].in_state[63:0]);
        end
        run_cnt++;
      end
      if (resp_valid != '0 || (timeout_err && !prev_to)) begin
        if (sb.size() == 0) begin
          checkOutput("response_expected", 1'b0, 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          if (e.is_timeout) begin
            checkOutput("timeout_no_resp", resp_valid == '0 && timeout_err && !prev_to,
                        {60'b0, resp_valid, timeout_err}, 64'd1);
          end else begin
            checkOutput("resp_valid", resp_valid == (N'(1) << e.id), 64'(resp_valid), 64'(1) << e.id);
            checkOutput("resp_state", resp_state == e.out_state, resp_state[63:0], e.out_state[63:0]);
            checkOutput("grant_id", grant_id == IW'(e.id), 64'(grant_id), 64'(e.id));
          end
          checkOutput("run_length", run_cnt == e.run_len, 64'(run_cnt), 64'(e.run_len));
          checkOutput("gap_enable_low", !perm_enable, 64'(perm_enable), 64'd0);
        end
        run_cnt = 0;
      end
      prev_en = perm_enable;
      prev_to = timeout_err;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish, required finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [N-1:0] m;
    req_valid = '0;
    req_state = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_outputs", resp_valid == '0 && !busy && !perm_enable && grant_id == '0 && !timeout_err,
                {57'b0, resp_valid, busy, perm_enable, grant_id, timeout_err}, 64'd0);
    checkOutput("reset_data", perm_in == '0 && resp_state == '0, perm_in[63:0] | resp_state[63:0], 64'd0);
    @(negedge clk);
    rst = 1'b0;

    randomizeStates(3'b111);
    applyStimulus(3'b111, 12, 1'b0, 3, -1);

    req_state[1600 +: 1600] = {25{64'h0123_4567_89AB_CDEF}};
    applyStimulus(3'b010, 24, 1'b0, 0, -1);

    randomizeStates(3'b111);
    applyStimulus(3'b100, 7, 1'b0, 0, -1);
    applyStimulus(3'b101, 5, 1'b0, 0, -1);

    randomizeStates(3'b011);
    applyStimulus(3'b001, 20, 1'b0, 0, 5);
    applyStimulus(3'b011, 8, 1'b0, 0, -1);

    for (int t = 0; t < 6; t++) begin
      m = N'($urandom_range(1, 7));
      randomizeStates(m);
      applyStimulus(m, $urandom_range(0, 40), 1'b0, $urandom_range(0, 2), -1);
    end

    @(negedge clk);
    spurious = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("spurious_valid_idle", !busy && resp_valid == '0, {62'b0, busy, |resp_valid}, 64'd0);
    spurious = 1'b0;

    randomizeStates(3'b011);
    applyStimulus(3'b001, 10, 1'b1, 0, -1);
    stall_perm = 1'b0;
    applyStimulus(3'b011, 6, 1'b0, 0, -1);
    checkOutput("timeout_sticky", timeout_err == 1'b1, 64'(timeout_err), 64'd1);

    randomizeStates(3'b100);
    lat = 30;
    modelServe(3'b100, 0, 1'b0);
    @(negedge clk);
    req_valid = 3'b100;
    repeat (6) @(negedge clk);
    checkOutput("run_before_reset", perm_enable && busy, {62'b0, busy, perm_enable}, 64'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrun_reset_ctrl", resp_valid == '0 && !busy && !perm_enable && grant_id == '0 && !timeout_err,
                {57'b0, resp_valid, busy, perm_enable, grant_id, timeout_err}, 64'd0);
    checkOutput("midrun_reset_perm_in", perm_in == '0, perm_in[63:0], 64'd0);
    checkOutput("midrun_reset_resp_state", resp_state == '0, resp_state[63:0], 64'd0);
    sb.delete();
    model_ptr = 0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    randomizeStates(3'b111);
    applyStimulus(3'b111, 9, 1'b0, 0, -1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size() == 0, 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
